// File: rtl/ddr2_test_data_gen_pkg.sv
// Shared DDR2 parameters and write-FSM encodings for the self-test data generator.
package ddr2_test_data_gen_pkg;

    localparam int unsigned DDR2_DQ_WIDTH  = 32;
    localparam int unsigned DDR2_DM_WIDTH  = DDR2_DQ_WIDTH / 8;
    localparam int unsigned DDR2_BURST_LEN = 4;
    localparam int unsigned DDR2_BEATS     = DDR2_BURST_LEN / 2;

    // Wide enough for BURST_LEN 8 (four beats per burst).
    localparam int unsigned BEAT_W = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StDone  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/ddr2_pattern_beat.sv
// Deterministic test pattern: byte seed+beat on the rising word, its inverse on the falling word.
module ddr2_pattern_beat
    import ddr2_test_data_gen_pkg::*;
#(
    parameter int unsigned DQ_WIDTH = DDR2_DQ_WIDTH
) (
    input  logic [7:0]            seed,
    input  logic [BEAT_W-1:0]     beat,
    output logic [2*DQ_WIDTH-1:0] pattern
);

    logic [7:0] pat_byte;

    always_comb begin
        pat_byte = seed + 8'(beat);
        pattern  = {{(DQ_WIDTH/8){pat_byte}}, {(DQ_WIDTH/8){~pat_byte}}};
    end

endmodule

// File: rtl/ddr2_test_data_gen.sv
// DDR2 self-test traffic generator: write-burst data, matching read-compare data and
// outstanding-burst bookkeeping with a sticky read-underflow flag.
module ddr2_test_data_gen
    import ddr2_test_data_gen_pkg::*;
#(
    parameter int unsigned DQ_WIDTH  = DDR2_DQ_WIDTH,
    parameter int unsigned DM_WIDTH  = DDR2_DM_WIDTH,
    parameter int unsigned BURST_LEN = DDR2_BURST_LEN,
    parameter logic [7:0]  SEED_INIT = 8'h00,
    parameter int unsigned OUTST_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic                  inject_err,
    input  logic                  wdf_full,
    output logic                  app_wdf_wren,
    output logic [2*DQ_WIDTH-1:0] app_wdf_data,
    output logic [DM_WIDTH-1:0]   app_mask_data,
    output logic                  wr_busy,
    output logic                  wr_burst_done,
    input  logic                  read_data_valid,
    output logic [2*DQ_WIDTH-1:0] app_compare_data,
    output logic [OUTST_W-1:0]    outstanding,
    output logic                  rd_underflow
);

    localparam int unsigned         BEATS      = BURST_LEN / 2;
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [7:0]          SEED_STEP  = 8'(BEATS);
    localparam logic [OUTST_W-1:0]  OUTST_MAX  = '1;
    localparam logic [2*DQ_WIDTH-1:0] RESET_DATA =
        {{(DQ_WIDTH/8){SEED_INIT}}, {(DQ_WIDTH/8){~SEED_INIT}}};

    wr_state_e             wr_state;
    logic [7:0]            wr_seed;
    logic [BEAT_W-1:0]     wr_beat;
    logic [BEAT_W-1:0]     wr_load_beat;
    logic [2*DQ_WIDTH-1:0] wr_pattern;
    logic [2*DQ_WIDTH-1:0] err_mask;
    logic                  wr_accept;
    logic                  wr_complete;

    logic [7:0]            rd_seed;
    logic [BEAT_W-1:0]     rd_beat;
    logic                  rd_complete;

    // The pattern generator always looks at the beat about to be loaded into the output register.
    assign wr_load_beat = (wr_state == StBurst) ? wr_beat + BEAT_W'(1) : '0;
    assign err_mask     = {{(2*DQ_WIDTH-1){1'b0}}, inject_err};
    assign wr_accept    = app_wdf_wren & ~wdf_full;
    assign wr_complete  = (wr_state == StBurst) & wr_accept & (wr_beat == LAST_BEAT);
    assign rd_complete  = read_data_valid & (rd_beat == LAST_BEAT);

    assign app_mask_data = '0;

    ddr2_pattern_beat #(
        .DQ_WIDTH (DQ_WIDTH)
    ) u_wr_pattern (
        .seed    (wr_seed),
        .beat    (wr_load_beat),
        .pattern (wr_pattern)
    );

    ddr2_pattern_beat #(
        .DQ_WIDTH (DQ_WIDTH)
    ) u_rd_pattern (
        .seed    (rd_seed),
        .beat    (rd_beat),
        .pattern (app_compare_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state      <= StIdle;
            wr_seed       <= SEED_INIT;
            wr_beat       <= '0;
            app_wdf_wren  <= 1'b0;
            app_wdf_data  <= RESET_DATA;
            wr_busy       <= 1'b0;
            wr_burst_done <= 1'b0;
        end else begin
            case (wr_state)
                StIdle: begin
                    wr_burst_done <= 1'b0;
                    if (wr_req) begin
                        wr_state     <= StBurst;
                        wr_beat      <= '0;
                        app_wdf_wren <= 1'b1;
                        app_wdf_data <= wr_pattern ^ err_mask;
                        wr_busy      <= 1'b1;
                    end
                end
                StBurst: begin
                    if (wr_accept) begin
                        if (wr_beat == LAST_BEAT) begin
                            wr_state      <= StDone;
                            app_wdf_wren  <= 1'b0;
                            wr_burst_done <= 1'b1;
                            wr_seed       <= wr_seed + SEED_STEP;
                        end else begin
                            wr_beat      <= wr_beat + BEAT_W'(1);
                            app_wdf_data <= wr_pattern ^ err_mask;
                        end
                    end
                end
                StDone: begin
                    wr_state      <= StIdle;
                    wr_burst_done <= 1'b0;
                    wr_busy       <= 1'b0;
                end
                default: begin
                    wr_state      <= StIdle;
                    app_wdf_wren  <= 1'b0;
                    wr_busy       <= 1'b0;
                    wr_burst_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_seed <= SEED_INIT;
            rd_beat <= '0;
        end else if (read_data_valid) begin
            if (rd_beat == LAST_BEAT) begin
                rd_beat <= '0;
                rd_seed <= rd_seed + SEED_STEP;
            end else begin
                rd_beat <= rd_beat + BEAT_W'(1);
            end
        end
    end

    // A write completion and a read completion in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({wr_complete, rd_complete})
                2'b10: if (outstanding != OUTST_MAX) outstanding <= outstanding + 1'b1;
                2'b01: if (outstanding != '0) outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_underflow <= 1'b0;
        end else if (read_data_valid && (outstanding == '0)) begin
            rd_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr2_test_data_gen.sv
// Scoreboard bench for ddr2_test_data_gen: directed bursts and reads with hand-derived patterns.
module tb_ddr2_test_data_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req;
    logic        inject_err;
    logic        wdf_full;
    logic        app_wdf_wren;
    logic [63:0] app_wdf_data;
    logic [3:0]  app_mask_data;
    logic        wr_busy;
    logic        wr_burst_done;
    logic        read_data_valid;
    logic [63:0] app_compare_data;
    logic [7:0]  outstanding;
    logic        rd_underflow;

    logic [63:0] wr_q[$];
    logic [63:0] rd_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          wren_cycles = 0;
    logic [7:0]  wr_seed_m;
    logic [7:0]  rd_seed_m;
    int          rd_beat_m;

    always #5 clk = ~clk;

    ddr2_test_data_gen #(
        .DQ_WIDTH  (32),
        .DM_WIDTH  (4),
        .BURST_LEN (4),
        .SEED_INIT (8'h00),
        .OUTST_W   (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_req           (wr_req),
        .inject_err       (inject_err),
        .wdf_full         (wdf_full),
        .app_wdf_wren     (app_wdf_wren),
        .app_wdf_data     (app_wdf_data),
        .app_mask_data    (app_mask_data),
        .wr_busy          (wr_busy),
        .wr_burst_done    (wr_burst_done),
        .read_data_valid  (read_data_valid),
        .app_compare_data (app_compare_data),
        .outstanding      (outstanding),
        .rd_underflow     (rd_underflow)
    );

    function automatic logic [63:0] pat(input logic [7:0] b);
        return {{4{b}}, {4{~b}}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an accepted write beat or a read beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (app_wdf_wren) wren_cycles++;
            if (app_wdf_wren && !wdf_full) begin
                if (wr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL wr_unexpected: got beat %h, expected no beat", app_wdf_data);
                end else begin
                    check("wr_data", app_wdf_data, wr_q.pop_front());
                end
            end
            if (read_data_valid) begin
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_unexpected: got %h, expected no read", app_compare_data);
                end else begin
                    check("cmp_data", app_compare_data, rd_q.pop_front());
                end
            end
        end
    end

    task automatic reset_models();
        wr_seed_m = 8'h00;
        rd_seed_m = 8'h00;
        rd_beat_m = 0;
    endtask

    task automatic check_reset_state();
        check("rst_wren", app_wdf_wren, 0);
        check("rst_busy", wr_busy, 0);
        check("rst_done", wr_burst_done, 0);
        check("rst_outst", outstanding, 0);
        check("rst_underflow", rd_underflow, 0);
        check("rst_wdata", app_wdf_data, 64'h00000000_FFFFFFFF);
        check("rst_cdata", app_compare_data, 64'h00000000_FFFFFFFF);
        check("rst_mask", app_mask_data, 0);
    endtask

    task automatic apply_reset();
        check("wr_q_drained", wr_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        wr_q.delete();
        rd_q.delete();
        reset = 1'b1;
        reset_models();
        @(posedge clk); #1;
        check_reset_state();
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Called 1 time unit after a rising edge with the write FSM idle.
    task automatic do_burst(input logic inj, input int stall_beat, input int stall_n,
                            input int exp_outst);
        logic [63:0] e;
        int          c0;
        int          stalls;
        stalls = 0;
        for (int b = 0; b < 2; b++) begin
            e = pat(wr_seed_m + 8'(b));
            if (b == 0 && inj) e[0] = ~e[0];
            wr_q.push_back(e);
        end
        c0         = wren_cycles;
        wr_req     = 1'b1;
        inject_err = inj;
        @(posedge clk); #1;
        wr_req     = 1'b0;
        inject_err = 1'b0;
        check("burst_busy", wr_busy, 1);
        for (int k = 0; k < 2; k++) begin
            if (k == stall_beat) begin
                wdf_full = 1'b1;
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk); #1;
                    check("done_early", wr_burst_done, 0);
                    stalls++;
                end
                wdf_full = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("done_pulse", wr_burst_done, 1);
        check("done_wren", app_wdf_wren, 0);
        check("done_busy", wr_busy, 1);
        @(posedge clk); #1;
        check("idle_done", wr_burst_done, 0);
        check("idle_busy", wr_busy, 0);
        check("burst_outst", outstanding, 64'(exp_outst));
        check("wren_cycles", wren_cycles - c0, 64'(2 + stalls));
        wr_seed_m = wr_seed_m + 8'd2;
    endtask

    task automatic push_read();
        rd_q.push_back(pat(rd_seed_m + 8'(rd_beat_m)));
        if (rd_beat_m == 1) begin
            rd_beat_m = 0;
            rd_seed_m = rd_seed_m + 8'd2;
        end else begin
            rd_beat_m++;
        end
    endtask

    task automatic do_read(input int n);
        for (int i = 0; i < n; i++) begin
            push_read();
            read_data_valid = 1'b1;
            @(posedge clk); #1;
        end
        read_data_valid = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        wr_req          = 1'b0;
        inject_err      = 1'b0;
        wdf_full        = 1'b0;
        read_data_valid = 1'b0;
        reset_models();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        @(posedge clk); #1;

        // Two back-to-back bursts, then read both back and overrun by one beat.
        do_burst(1'b0, -1, 0, 1);
        do_burst(1'b0, -1, 0, 2);
        do_read(4);
        check("outst_drained", outstanding, 0);
        check("no_underflow", rd_underflow, 0);
        do_read(1);
        check("underflow_set", rd_underflow, 1);
        check("outst_floor", outstanding, 0);

        // FIFO full for three cycles while beat 1 is presented.
        do_burst(1'b0, 1, 3, 1);
        check("underflow_sticky", rd_underflow, 1);

        // Error injection on beat 0 only touches the written data.
        apply_reset();
        do_burst(1'b1, -1, 0, 1);
        do_read(2);
        check("inj_outst", outstanding, 0);
        check("inj_underflow", rd_underflow, 0);

        // Reset in the middle of a burst, after beat 0 has been accepted.
        apply_reset();
        wr_q.push_back(pat(8'h00));
        wr_req = 1'b1;
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(posedge clk); #1;
        check("mid_wren", app_wdf_wren, 1);
        #1;
        reset = 1'b1;
        #1;
        check("async_wren", app_wdf_wren, 0);
        check("async_busy", wr_busy, 0);
        check("async_wdata", app_wdf_data, 64'h00000000_FFFFFFFF);
        check("async_outst", outstanding, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        reset_models();
        @(posedge clk); #1;
        do_burst(1'b0, -1, 0, 1);

        // Last write beat and last read beat land on the same edge.
        wr_q.push_back(pat(8'h02));
        wr_q.push_back(pat(8'h03));
        wr_req = 1'b1;
        @(posedge clk); #1;
        wr_req = 1'b0;
        push_read();
        read_data_valid = 1'b1;
        @(posedge clk); #1;
        push_read();
        @(posedge clk); #1;
        read_data_valid = 1'b0;
        check("sim_done", wr_burst_done, 1);
        check("sim_outst", outstanding, 1);
        @(posedge clk); #1;
        check("sim_outst_idle", outstanding, 1);
        check("sim_underflow", rd_underflow, 0);
        wr_seed_m = wr_seed_m + 8'd2;

        check("wr_q_empty", wr_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr2_test_data_gen.md
Name: ddr2_test_data_gen

Overview:
- Traffic-side data generator for the DDR2 self-test path. It produces the write-data beats pushed into the controller write-data FIFO.
- It independently regenerates the same deterministic sequence as `app_compare_data`, which feeds the read-data comparator.
- It tracks outstanding written bursts so that read data arriving with nothing written behind it is flagged.
- Bus order matches the comparator: upper `DQ_WIDTH` bits = rising-edge word, lower `DQ_WIDTH` bits = falling-edge word.

Parameters:
- `DQ_WIDTH`, 32, DDR2 data width; internal buses are `2*DQ_WIDTH`.
- `DM_WIDTH`, 4, data-mask width (`DQ_WIDTH/8`).
- `BURST_LEN`, 4, DDR2 burst length; beats per burst `BEATS = BURST_LEN/2` (2 or 4).
- `SEED_INIT`, 8'h00, byte seed after reset.
- `OUTST_W`, 8, width of the outstanding-burst counter.

Ports:
- `clk`  in  1  controller clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_req`  in  1  pulse: request one write burst.
- `inject_err`  in  1  when high at a beat issue, bit 0 of that written beat is inverted.
- `wdf_full`  in  1  write-data FIFO full; stalls write beats.
- `app_wdf_wren`  out  1  write-data beat valid.
- `app_wdf_data`  out  2*DQ_WIDTH  write-data beat.
- `app_mask_data`  out  DM_WIDTH  write mask; constant 0.
- `wr_busy`  out  1  write burst in progress.
- `wr_burst_done`  out  1  one-cycle pulse after the last beat is accepted.
- `read_data_valid`  in  1  read beat present this cycle.
- `app_compare_data`  out  2*DQ_WIDTH  expected data for the current read beat.
- `outstanding`  out  OUTST_W  written bursts not yet fully read back.
- `rd_underflow`  out  1  sticky flag: a read beat arrived with `outstanding == 0`.

Behaviour:
- Pattern:
  - byte `b = seed + beat` (8-bit wrap).
  - Rising word = `b` replicated `DQ_WIDTH/8` times; falling word = `~b` replicated.
  - Each seed advances by `BEATS` per completed burst (mod 256).
  - The write side and the compare side keep separate seeds and beat counters.
- Reset (async): write FSM = IDLE; both seeds = `SEED_INIT`; beat counters = 0; `outstanding` = 0; `rd_underflow` = 0; `app_wdf_wren` = 0; `wr_busy` = 0; `wr_burst_done` = 0. `app_wdf_data` = `app_compare_data` = pattern for seed `SEED_INIT`, beat 0.
- Write FSM states: IDLE, BURST, DONE.
  - IDLE: `wr_req` = 1 → BURST, beat = 0. `wr_req` is ignored in BURST and DONE (no queueing).
  - BURST: registered outputs. `app_wdf_wren` = 1 and `app_wdf_data` = pattern(wr_seed, beat), with bit 0 inverted if `inject_err` was sampled high when that beat was loaded.
    - A beat is accepted on a cycle with `app_wdf_wren` = 1 and `wdf_full` = 0.
    - While `wdf_full` = 1: hold `wren`, data and beat unchanged.
    - After the beat `BEATS-1` is accepted → DONE.
  - DONE (one cycle): `wr_burst_done` = 1, `wren` = 0, `wr_seed += BEATS`, `outstanding += 1` → IDLE.
  - `wr_busy` = 1 in BURST and DONE.
  - Latency: `wr_req` to first `wren` = 1 cycle; full-speed burst = `BEATS` cycles, then 1 DONE cycle.
- Compare side:
  - `app_compare_data` is combinational from `rd_seed`/`rd_beat`, so it is valid in the cycle `read_data_valid` is high.
  - On `read_data_valid`: `rd_beat++`. On wrap at `BEATS-1`: `rd_beat` = 0, `rd_seed += BEATS`, `outstanding -= 1`.
  - Error injection never affects `app_compare_data`.
- `outstanding`:
  - DONE and read-burst completion in the same cycle → unchanged.
  - Saturates at max; never decrements below 0.
- `rd_underflow`: set when `read_data_valid` = 1 and `outstanding` = 0. Cleared only by reset.
- Reset mid-burst: outputs drop to their reset values immediately. A partial burst is not counted.

Decomposition:
- Shared package/include: `DQ_WIDTH`, `DM_WIDTH`, `BURST_LEN` (existing DDR2 parameters file), write FSM state encodings, `BEATS` constant.
- One natural sub-module: `ddr2_pattern_beat`, combinational seed + beat → `2*DQ_WIDTH` pattern. Instantiated twice, once for the write side and once for the compare side.

Test Plan (`DQ_WIDTH` = 32, `BURST_LEN` = 4, `SEED_INIT` = 0):
1. Reset, then a single `wr_req`, `wdf_full` = 0 → `wren` high 2 cycles: data 0x00000000_FFFFFFFF, then 0x01010101_FEFEFEFE. Then `wr_burst_done` pulses and `outstanding` = 1.
2. Second burst → 0x02020202_FDFDFDFD, 0x03030303_FCFCFCFC. `outstanding` = 2.
3. `wdf_full` high 3 cycles on beat 1 → beat-1 data held 4 cycles; `wr_burst_done` only after acceptance; no beat duplicated or dropped.
4. After case 2, four `read_data_valid` beats → `app_compare_data` = 0x00000000_FFFFFFFF, 0x01010101_FEFEFEFE, 0x02020202_FDFDFDFD, 0x03030303_FCFCFCFC. `outstanding` returns to 0. A fifth read beat sets `rd_underflow`.
5. `inject_err` during beat 0 → written data 0x00000000_FFFFFFFE; the compare side still expects 0x00000000_FFFFFFFF.
6. Assert `reset` mid-burst (after beat 0) → `wren` = 0 asynchronously. The next burst restarts at 0x00000000_FFFFFFFF with `outstanding` = 0. Also check that simultaneous DONE and read-burst completion leave `outstanding` unchanged.
